axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-client AXI4 read-channel arbiter between the instruction-fetch path (icache refill, client 1) and the load/store unit (client 2) on one side, and the single AXI4 read master port toward memory on the other. It grants one whole transaction at a time (AR handshake through the final R beat), alternates between clients round-robin, and tracks burst length to flag protocol errors. Write channels are out of scope and are not routed here.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, read data width

Ports (suffix 1 = IFU/icache client, 2 = LSU client, no suffix = memory side):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- araddr1/araddr2  in  ADDR_W  client read address
- arvalid1/arvalid2  in  1  client address valid
- arburst1/arburst2  in  2  burst type, passed through
- arlen1/arlen2  in  8  beats minus one
- arsize1/arsize2  in  3  beat size, passed through
- arready1/arready2  out  1  address accepted
- rdata1/rdata2  out  DATA_W  read data
- rresp1/rresp2  out  2  read response
- rvalid1/rvalid2  out  1  read beat valid
- rlast1/rlast2  out  1  last beat
- rready1/rready2  in  1  client accepts beat
- araddr, arburst, arlen, arsize  out  ADDR_W/2/8/3  forwarded AR fields
- arvalid  out  1  forwarded address valid
- arready  in  1  memory accepts address
- rdata  in  DATA_W; rresp  in  2; rvalid  in  1; rlast  in  1  memory R channel
- rready  out  1  forwarded client rready
- burst_err  out  1  sticky burst-length error flag

## Operation
- States: IDLE, AR1, R1, AR2, R2. Register last_grant (1 bit, resets to "client 2", so client 1 wins the first tie).
- IDLE: if only one client asserts arvalid, go to that client's AR state. If both, go to the client not equal to last_grant. Otherwise stay.
- ARx: AR fields and arvalid are combinationally forwarded from client x; arreadyx = arready. On arvalid&&arready: latch arlen into len_q, clear beat_cnt, go to Rx. If client x drops arvalid before the handshake, return to IDLE; last_grant is unchanged.
- Rx: rdatax/rrespx/rvalidx/rlastx = memory R signals; rready = rreadyx. On each rvalid&&rready, beat_cnt increments (9 bits). On a beat with rlast: go to IDLE, last_grant = x.
- Ungranted client: arready, rvalid, and rlast are 0; rdata and rresp are 0. In any state other than ARx, arvalid is 0 and araddr/arburst/arlen/arsize are 0. rready is 0 outside R states. A memory rvalid outside R states is ignored and never acknowledged.
- burst_err is set and held until reset in either case:
  - rlast accepted while beat_cnt != len_q;
  - a beat without rlast accepted while beat_cnt == len_q.
  The transaction still ends only on rlast. rresp errors (SLVERR/DECERR) are passed through and do not set burst_err.
- Exactly one outstanding transaction. No AR is forwarded while in R states.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, last_grant=2, beat_cnt=0, len_q=0, burst_err=0. All outputs go to 0 immediately.
- Reset in mid-transaction abandons the burst. Any remaining memory beats arriving after release are ignored, with rready=0.
- Grant latency: a client's arvalid seen in IDLE at edge N produces memory arvalid during cycle N+1 (one registered cycle).
- AR to R: the cycle after the AR handshake, rready follows the client. Zero-latency pass-through per beat.
- Back-to-back: the cycle after the rlast beat is IDLE. The next AR reaches memory 2 cycles after the rlast edge.
- Simultaneous requests with both clients continuously requesting: grants alternate 1,2,1,2…

## Test plan
- Single client-1 request: araddr1=0x80000000, arlen1=1 (2 beats), arready high, memory returns 0x11,0x22 with rlast on beat 2. Required: arvalid one cycle after arvalid1; client 1 receives both beats and rlast1; rvalid2 stays 0; burst_err=0.
- Both arvalid1 and arvalid2 asserted from reset, both with arlen=0. Required: order 1,2,1; memory araddr matches the granted client each time.
- Client-2 burst with arlen=3 and rready2 toggled 1,0,1,0,1,1. Required: memory rready mirrors rready2; exactly 4 beats delivered; return to IDLE after beat 4.
- Memory asserts rlast on beat 2 for arlen=3. Required: burst_err=1 and stays 1; state returns to IDLE; the next request is served normally.
- Reset asserted mid-R1 after 1 of 4 beats, then released while memory keeps driving rvalid. Required: all outputs 0 during reset; rready=0 after release; a new client-2 request is granted first (last_grant=2 → client 1 preferred only on a tie).
- arvalid1 drops during AR1 with arready held low. Required: return to IDLE; memory arvalid=0 the next cycle; no burst_err.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by both clients and the memory port.
interface axi_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic [1:0]        arburst;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rlast;
  logic              rready;

  // Requester side: issues AR, consumes R.
  modport master (
    output araddr, arvalid, arburst, arlen, arsize, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  // Responder side: accepts AR, produces R.
  modport slave (
    input  araddr, arvalid, arburst, arlen, arsize, rready,
    output arready, rdata, rresp, rvalid, rlast
  );

endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-client AXI4 read arbiter: one whole transaction at a time, round-robin
// between icache refill (c1) and LSU (c2), with a sticky burst-length error flag.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  axi_rd_arbiter_if.slave     c1,
  axi_rd_arbiter_if.slave     c2,
  axi_rd_arbiter_if.master    m,
  output logic                burst_err
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned CNT_W = LEN_W + 1;

  // last_grant encoding: 0 = client 1 served last, 1 = client 2 served last
  localparam logic GRANT_C1 = 1'b0;
  localparam logic GRANT_C2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    AR1,
    R1,
    AR2,
    R2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] beat_cnt;

  logic ar_fire;
  logic r_fire;
  logic len_hit;

  // Handshakes on the memory side; rready/arvalid are already gated by state.
  assign ar_fire = m.arvalid && m.arready;
  assign r_fire  = m.rvalid && m.rready;
  assign len_hit = (beat_cnt == CNT_W'(len_q));

  // Steer AR from the granted client to memory and R from memory to that client.
  always_comb begin
    m.araddr   = {ADDR_W{1'b0}};
    m.arvalid  = 1'b0;
    m.arburst  = 2'b00;
    m.arlen    = 8'h00;
    m.arsize   = 3'b000;
    m.rready   = 1'b0;
    c1.arready = 1'b0;
    c1.rdata   = {DATA_W{1'b0}};
    c1.rresp   = 2'b00;
    c1.rvalid  = 1'b0;
    c1.rlast   = 1'b0;
    c2.arready = 1'b0;
    c2.rdata   = {DATA_W{1'b0}};
    c2.rresp   = 2'b00;
    c2.rvalid  = 1'b0;
    c2.rlast   = 1'b0;
    case (state)
      AR1: begin
        m.araddr   = c1.araddr;
        m.arvalid  = c1.arvalid;
        m.arburst  = c1.arburst;
        m.arlen    = c1.arlen;
        m.arsize   = c1.arsize;
        c1.arready = m.arready;
      end
      R1: begin
        c1.rdata  = m.rdata;
        c1.rresp  = m.rresp;
        c1.rvalid = m.rvalid;
        c1.rlast  = m.rlast;
        m.rready  = c1.rready;
      end
      AR2: begin
        m.araddr   = c2.araddr;
        m.arvalid  = c2.arvalid;
        m.arburst  = c2.arburst;
        m.arlen    = c2.arlen;
        m.arsize   = c2.arsize;
        c2.arready = m.arready;
      end
      R2: begin
        c2.rdata  = m.rdata;
        c2.rresp  = m.rresp;
        c2.rvalid = m.rvalid;
        c2.rlast  = m.rlast;
        m.rready  = c2.rready;
      end
      default: ;
    endcase
  end

  // Grant FSM, burst length tracking and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_C2;
      len_q      <= '0;
      beat_cnt   <= '0;
      burst_err  <= 1'b0;
    end else begin
      if (r_fire) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        // rlast must coincide exactly with the beat numbered arlen
        if (m.rlast != len_hit) begin
          burst_err <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (c1.arvalid && (!c2.arvalid || (last_grant == GRANT_C2))) begin
            state <= AR1;
          end else if (c2.arvalid) begin
            state <= AR2;
          end
        end
        AR1: begin
          if (ar_fire) begin
            len_q    <= m.arlen;
            beat_cnt <= '0;
            state    <= R1;
          end else if (!c1.arvalid) begin
            state <= IDLE;
          end
        end
        R1: begin
          if (r_fire && m.rlast) begin
            state      <= IDLE;
            last_grant <= GRANT_C1;
          end
        end
        AR2: begin
          if (ar_fire) begin
            len_q    <= m.arlen;
            beat_cnt <= '0;
            state    <= R2;
          end else if (!c2.arvalid) begin
            state <= IDLE;
          end
        end
        R2: begin
          if (r_fire && m.rlast) begin
            state      <= IDLE;
            last_grant <= GRANT_C2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: stimulus pushes expected AR and R
// transfers into queues, a monitor pops and compares on each DUT handshake.
module tb_axi_rd_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic burst_err;

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c1 ();
  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c2 ();
  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .c1        (c1.slave),
    .c2        (c2.slave),
    .m         (m.master),
    .burst_err (burst_err)
  );

  ar_t   req1_q[$];
  ar_t   req2_q[$];
  ar_t   exp_ar_q[$];
  beat_t mem_q[$];
  beat_t exp_r1_q[$];
  beat_t exp_r2_q[$];
  logic  rr2_pat[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  task automatic push_req(input int cl, input logic [31:0] a, input logic [7:0] l, input bit exp_ar);
    ar_t r;
    r.addr = a;
    r.len  = l;
    if (cl == 1) req1_q.push_back(r);
    else         req2_q.push_back(r);
    if (exp_ar) exp_ar_q.push_back(r);
  endtask

  task automatic push_beat(input int cl, input logic [63:0] d, input logic [1:0] rs, input logic l);
    beat_t b;
    b.data = d;
    b.resp = rs;
    b.last = l;
    mem_q.push_back(b);
    if (cl == 1) exp_r1_q.push_back(b);
    else         exp_r2_q.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_ar_q.size() != 0 || exp_r1_q.size() != 0 || exp_r2_q.size() != 0 ||
            req1_q.size() != 0 || req2_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n >= max_cyc), 64'(0));
    @(negedge clk);
    @(negedge clk);
  endtask

  // Client 1 request driver: holds the queue head until it is accepted.
  initial begin
    logic hs1;
    c1.arvalid = 1'b0; c1.araddr = '0; c1.arburst = 2'b00; c1.arlen = 8'h00;
    c1.arsize = 3'b000; c1.rready = 1'b1;
    forever begin
      @(negedge clk);
      hs1 = c1.arvalid && c1.arready;
      @(posedge clk);
      #1;
      if (hs1 && req1_q.size() != 0) void'(req1_q.pop_front());
      if (req1_q.size() != 0) begin
        c1.arvalid = 1'b1; c1.araddr = req1_q[0].addr; c1.arlen = req1_q[0].len;
        c1.arburst = 2'b01; c1.arsize = 3'd3;
      end else begin
        c1.arvalid = 1'b0; c1.araddr = '0; c1.arlen = 8'h00;
        c1.arburst = 2'b00; c1.arsize = 3'd0;
      end
    end
  end

  // Client 2 request driver plus optional per-cycle rready pattern.
  initial begin
    logic hs2;
    c2.arvalid = 1'b0; c2.araddr = '0; c2.arburst = 2'b00; c2.arlen = 8'h00;
    c2.arsize = 3'b000; c2.rready = 1'b1;
    forever begin
      @(negedge clk);
      hs2 = c2.arvalid && c2.arready;
      @(posedge clk);
      #1;
      if (hs2 && req2_q.size() != 0) void'(req2_q.pop_front());
      if (req2_q.size() != 0) begin
        c2.arvalid = 1'b1; c2.araddr = req2_q[0].addr; c2.arlen = req2_q[0].len;
        c2.arburst = 2'b01; c2.arsize = 3'd3;
      end else begin
        c2.arvalid = 1'b0; c2.araddr = '0; c2.arlen = 8'h00;
        c2.arburst = 2'b00; c2.arsize = 3'd0;
      end
      if (rr2_pat.size() != 0) c2.rready = rr2_pat.pop_front();
      else                     c2.rready = 1'b1;
    end
  end

  // Memory R model: presents the head beat whenever it has one.
  initial begin
    logic hsm;
    m.arready = 1'b1; m.rvalid = 1'b0; m.rdata = '0; m.rresp = 2'b00; m.rlast = 1'b0;
    forever begin
      @(negedge clk);
      hsm = m.rvalid && m.rready;
      @(posedge clk);
      #1;
      if (hsm && mem_q.size() != 0) void'(mem_q.pop_front());
      if (mem_q.size() != 0) begin
        m.rvalid = 1'b1; m.rdata = mem_q[0].data; m.rresp = mem_q[0].resp; m.rlast = mem_q[0].last;
      end else begin
        m.rvalid = 1'b0; m.rdata = '0; m.rresp = 2'b00; m.rlast = 1'b0;
      end
    end
  end

  // Monitor: compare every AR and R handshake against the scoreboard.
  initial begin
    ar_t   ea;
    beat_t eb;
    forever begin
      @(negedge clk);
      if (m.arvalid && m.arready) begin
        if (exp_ar_q.size() == 0) flag("ar_unexpected", 64'(m.araddr));
        else begin
          ea = exp_ar_q.pop_front();
          chk("ar_addr", 64'(m.araddr), 64'(ea.addr));
          chk("ar_len", 64'(m.arlen), 64'(ea.len));
          chk("ar_burst", 64'(m.arburst), 64'(2'b01));
          chk("ar_size", 64'(m.arsize), 64'(3'd3));
        end
      end
      if (c1.rvalid && c1.rready) begin
        if (exp_r1_q.size() == 0) flag("r1_unexpected", 64'(c1.rdata));
        else begin
          eb = exp_r1_q.pop_front();
          chk("r1_data", 64'(c1.rdata), eb.data);
          chk("r1_resp", 64'(c1.rresp), 64'(eb.resp));
          chk("r1_last", 64'(c1.rlast), 64'(eb.last));
        end
      end
      if (c2.rvalid && c2.rready) begin
        if (exp_r2_q.size() == 0) flag("r2_unexpected", 64'(c2.rdata));
        else begin
          eb = exp_r2_q.pop_front();
          chk("r2_data", 64'(c2.rdata), eb.data);
          chk("r2_resp", 64'(c2.rresp), 64'(eb.resp));
          chk("r2_last", 64'(c2.rlast), 64'(eb.last));
        end
      end
    end
  end

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    logic [5:0] pat;
    int n;

    // Both clients requesting from reset; beats queued so memory rvalid is high in reset.
    push_req(1, 32'h0000_1000, 8'd0, 1'b1);
    push_req(1, 32'h0000_1100, 8'd0, 1'b1);
    push_req(2, 32'h0000_2000, 8'd0, 1'b1);
    exp_ar_q.delete();
    exp_ar_q.push_back('{addr: 32'h0000_1000, len: 8'd0});
    exp_ar_q.push_back('{addr: 32'h0000_2000, len: 8'd0});
    exp_ar_q.push_back('{addr: 32'h0000_1100, len: 8'd0});
    push_beat(1, 64'hA1, 2'b00, 1'b1);
    push_beat(2, 64'hA2, 2'b00, 1'b1);
    push_beat(1, 64'hA3, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(m.arvalid), 64'(0));
    chk("rst_araddr", 64'(m.araddr), 64'(0));
    chk("rst_rready", 64'(m.rready), 64'(0));
    chk("rst_arready1", 64'(c1.arready), 64'(0));
    chk("rst_rvalid1", 64'(c1.rvalid), 64'(0));
    chk("rst_rdata1", 64'(c1.rdata), 64'(0));
    chk("rst_rvalid2", 64'(c2.rvalid), 64'(0));
    chk("rst_burst_err", 64'(burst_err), 64'(0));
    rst = 1'b1;
    wait_drain("t2_rr_drain", 60);

    // Single client-1 two-beat burst with grant latency check.
    push_req(1, 32'h8000_0000, 8'd1, 1'b1);
    push_beat(1, 64'h11, 2'b00, 1'b0);
    push_beat(1, 64'h22, 2'b00, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!c1.arvalid && n < 10);
    chk("t1_arvalid1_seen", 64'(c1.arvalid), 64'(1));
    chk("t1_lat_cycle0", 64'(m.arvalid), 64'(0));
    @(negedge clk);
    chk("t1_lat_cycle1", 64'(m.arvalid), 64'(1));
    wait_drain("t1_drain", 40);
    chk("t1_burst_err", 64'(burst_err), 64'(0));

    // Client-2 four-beat burst with throttled rready, one SLVERR beat.
    push_req(2, 32'h3000_0000, 8'd3, 1'b1);
    push_beat(2, 64'h31, 2'b00, 1'b0);
    push_beat(2, 64'h32, 2'b10, 1'b0);
    push_beat(2, 64'h33, 2'b00, 1'b0);
    push_beat(2, 64'h34, 2'b00, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(m.arvalid && m.arready) && n < 10);
    chk("t3_ar_seen", 64'(m.arvalid && m.arready), 64'(1));
    pat = 6'b110101;
    for (int i = 0; i < 6; i++) rr2_pat.push_back(pat[i]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_rready_mirror", 64'(m.rready), 64'(pat[i]));
    end
    @(negedge clk);
    chk("t3_idle_rready", 64'(m.rready), 64'(0));
    chk("t3_beats_left", 64'(exp_r2_q.size()), 64'(0));
    chk("t3_mem_left", 64'(mem_q.size()), 64'(0));
    chk("t3_burst_err", 64'(burst_err), 64'(0));

    // Early rlast on a 4-beat burst sets the sticky error; next request still served.
    push_req(1, 32'h4000_0000, 8'd3, 1'b1);
    push_beat(1, 64'h41, 2'b00, 1'b0);
    push_beat(1, 64'h42, 2'b00, 1'b1);
    wait_drain("t4_drain", 40);
    chk("t4_burst_err_set", 64'(burst_err), 64'(1));
    chk("t4_idle_rready", 64'(m.rready), 64'(0));
    push_req(2, 32'h4100_0000, 8'd0, 1'b1);
    push_beat(2, 64'h43, 2'b00, 1'b1);
    wait_drain("t4_next_drain", 40);
    chk("t4_burst_err_sticky", 64'(burst_err), 64'(1));

    // Reset in the middle of a client-1 burst after one beat.
    push_req(1, 32'h5000_0000, 8'd3, 1'b1);
    push_beat(1, 64'h51, 2'b00, 1'b0);
    push_beat(1, 64'h52, 2'b00, 1'b0);
    push_beat(1, 64'h53, 2'b00, 1'b0);
    push_beat(1, 64'h54, 2'b00, 1'b1);
    n = 0;
    while (exp_r1_q.size() > 3 && n < 20) begin @(negedge clk); n++; end
    chk("t5_first_beat", 64'(exp_r1_q.size()), 64'(3));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rst_arvalid", 64'(m.arvalid), 64'(0));
    chk("t5_rst_rready", 64'(m.rready), 64'(0));
    chk("t5_rst_rvalid1", 64'(c1.rvalid), 64'(0));
    chk("t5_rst_rdata1", 64'(c1.rdata), 64'(0));
    chk("t5_rst_rlast1", 64'(c1.rlast), 64'(0));
    chk("t5_rst_burst_err", 64'(burst_err), 64'(0));
    repeat (2) @(negedge clk);
    exp_r1_q.delete();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_post_rready", 64'(m.rready), 64'(0));
      chk("t5_post_rvalid1", 64'(c1.rvalid), 64'(0));
    end
    mem_q.delete();
    push_req(2, 32'h6000_0000, 8'd0, 1'b1);
    push_beat(2, 64'h61, 2'b00, 1'b1);
    wait_drain("t5_c2_drain", 40);

    // Client 1 abandons its request while memory holds arready low.
    m.arready = 1'b0;
    push_req(1, 32'h7000_0000, 8'd0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!m.arvalid && n < 10);
    chk("t6_arvalid_up", 64'(m.arvalid), 64'(1));
    req1_q.delete();
    @(negedge clk);
    chk("t6_arvalid_drop", 64'(m.arvalid), 64'(0));
    @(negedge clk);
    chk("t6_idle_arvalid", 64'(m.arvalid), 64'(0));
    chk("t6_burst_err", 64'(burst_err), 64'(0));
    m.arready = 1'b1;
    // Tie afterwards: client 2 was last served, so client 1 goes first.
    push_req(1, 32'h7100_0000, 8'd0, 1'b1);
    push_req(2, 32'h7200_0000, 8'd0, 1'b1);
    push_beat(1, 64'h71, 2'b00, 1'b1);
    push_beat(2, 64'h72, 2'b00, 1'b1);
    wait_drain("t6_tie_drain", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
